// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared constants, state and error encodings for the sudoku frame receiver
package sudoku_pkg;

  localparam int N_CELLS = 81;
  localparam int CELL_W  = 4;
  localparam int CNT_W   = 7;

  localparam logic [7:0] CH_START  = 8'h53;
  localparam logic [7:0] CH_DIGIT0 = 8'h30;
  localparam logic [7:0] CH_DIGIT9 = 8'h39;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_COMMA  = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BADCHAR = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_RESTART = 2'd3
  } err_t;

endpackage

// File: rtl/sudoku_ascii_classify.sv
// rtl/sudoku_ascii_classify.sv - combinational decode of one received ASCII byte
module sudoku_ascii_classify
  import sudoku_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_start,
  output logic       is_cell,
  output logic       is_skip,
  output logic [3:0] cell_val
);

  logic is_digit;

  assign is_digit = (data >= CH_DIGIT0) && (data <= CH_DIGIT9);
  assign is_start = (data == CH_START);
  assign is_cell  = is_digit || (data == CH_DOT);
  assign is_skip  = (data == CH_SP) || (data == CH_CR) || (data == CH_LF) || (data == CH_COMMA);
  // ASCII digits carry their value in the low nibble; '.' maps to an empty cell
  assign cell_val = is_digit ? data[3:0] : 4'd0;

endmodule

// File: rtl/sudoku_uart_board_rx.sv
// rtl/sudoku_uart_board_rx.sv - assembles an 'S'+81-cell ASCII frame into a 9x9 board
module sudoku_uart_board_rx
  import sudoku_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int TO_W           = 25
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_valid,
  output logic                        o_rx_ready,
  output logic [N_CELLS*CELL_W-1:0]   o_board,
  output logic                        o_board_valid,
  input  logic                        i_board_ready,
  output logic                        o_frame_err,
  output logic [1:0]                  o_err_code
);

  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(N_CELLS - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   timer;
  logic              accept;
  logic              timer_expired;
  logic              is_start;
  logic              is_cell;
  logic              is_skip;
  logic [3:0]        cell_val;

  sudoku_ascii_classify u_classify (
    .data     (i_rx_data),
    .is_start (is_start),
    .is_cell  (is_cell),
    .is_skip  (is_skip),
    .cell_val (cell_val)
  );

  assign o_rx_ready    = (state != ST_HOLD);
  assign accept        = i_rx_valid && o_rx_ready;
  assign timer_expired = (timer == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      timer         <= '0;
      o_board       <= '0;
      o_board_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      o_err_code    <= ERR_NONE;
    end else begin
      o_frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && is_start) begin
            state <= ST_RECV;
            cnt   <= '0;
            timer <= '0;
          end
        end
        ST_RECV: begin
          // an accepted byte always beats a timer expiring in the same cycle
          if (accept) begin
            timer <= '0;
            if (is_start) begin
              cnt         <= '0;
              o_frame_err <= 1'b1;
              o_err_code  <= ERR_RESTART;
            end else if (is_cell) begin
              o_board[cnt*CELL_W +: CELL_W] <= cell_val;
              if (cnt == LAST_CELL) begin
                state         <= ST_HOLD;
                o_board_valid <= 1'b1;
                cnt           <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else if (!is_skip) begin
              state       <= ST_IDLE;
              o_frame_err <= 1'b1;
              o_err_code  <= ERR_BADCHAR;
            end
          end else if (timer_expired) begin
            state       <= ST_IDLE;
            timer       <= '0;
            o_frame_err <= 1'b1;
            o_err_code  <= ERR_TIMEOUT;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        ST_HOLD: begin
          if (i_board_ready) begin
            state         <= ST_IDLE;
            o_board_valid <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_uart_board_rx.sv
// tb/tb_sudoku_uart_board_rx.sv - randomized self-checking bench with a frame-level reference model
module tb_sudoku_uart_board_rx;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [323:0] board;
  logic         board_valid;
  logic         board_ready = 1'b1;
  logic         frame_err;
  logic [1:0]   err_code;

  always #5 clk = ~clk;

  sudoku_uart_board_rx #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .o_rx_ready    (rx_ready),
    .o_board       (board),
    .o_board_valid (board_valid),
    .i_board_ready (board_ready),
    .o_frame_err   (frame_err),
    .o_err_code    (err_code)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs = 0;
  int err_pulses = 0;
  int valid_rises = 0;
  logic prev_valid = 1'b0;

  // reference model: mode 0 idle, 1 receiving, 2 holding a finished board
  int   m_mode = 0;
  int   m_idx = 0;
  int   m_idle = 0;
  int   m_cells[81];
  logic m_valid = 1'b0;
  logic m_err = 1'b0;
  logic [1:0] m_code = 2'd0;
  bit   m_acc;
  bit   chk_en = 0;

  logic [7:0] fq[$];
  logic [7:0] skips[4] = '{8'h20, 8'h0D, 8'h0A, 8'h2C};
  logic [7:0] bads[4]  = '{8'h78, 8'hFF, 8'h41, 8'h00};
  logic [7:0] junk[4]  = '{8'h41, 8'h31, 8'h2E, 8'h7A};

  task automatic check(input string name, input logic [323:0] act, input logic [323:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      m_mode = 0; m_idx = 0; m_idle = 0;
      m_valid = 1'b0; m_err = 1'b0; m_code = 2'd0;
      foreach (m_cells[i]) m_cells[i] = 0;
      chk_en = 1;
    end else begin
      m_acc = rx_valid && (m_mode != 2);
      m_err = 1'b0;
      case (m_mode)
        0: if (m_acc && rx_data == 8'h53) begin m_mode = 1; m_idx = 0; m_idle = 0; end
        1: if (m_acc) begin
             m_idle = 0;
             if (rx_data == 8'h53) begin
               m_idx = 0; m_err = 1'b1; m_code = 2'd3;
             end else if ((rx_data >= 8'h30 && rx_data <= 8'h39) || rx_data == 8'h2E) begin
               m_cells[m_idx] = (rx_data == 8'h2E) ? 0 : int'(rx_data) - 48;
               m_idx++;
               if (m_idx == 81) begin m_mode = 2; m_valid = 1'b1; m_idx = 0; end
             end else if (!(rx_data inside {8'h20, 8'h0D, 8'h0A, 8'h2C})) begin
               m_err = 1'b1; m_code = 2'd1; m_mode = 0;
             end
           end else if (m_idle == TO - 1) begin
             m_err = 1'b1; m_code = 2'd2; m_mode = 0;
           end else begin
             m_idle++;
           end
        default: if (board_ready) begin m_mode = 0; m_valid = 1'b0; end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [323:0] eb;
    if (chk_en) begin
      for (int k = 0; k < 81; k++) eb[4*k +: 4] = 4'(m_cells[k]);
      check("rx_ready", rx_ready, m_mode != 2);
      check("board_valid", board_valid, m_valid);
      check("frame_err", frame_err, m_err);
      check("err_code", err_code, m_code);
      check("board", board, eb);
      if (frame_err) err_pulses++;
      if (board_valid && !prev_valid) valid_rises++;
      prev_valid = board_valid;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit hs;
    int n;
    repeat (gap) @(posedge clk);
    if (gap > 0) #2;
    rx_data = b;
    rx_valid = 1'b1;
    hs = 0;
    n = 0;
    while (!hs && n < 3000) begin
      @(negedge clk);
      hs = rx_ready;
      @(posedge clk);
      #2;
      n++;
    end
    if (!hs) begin
      checks++; failures++;
      $display("FAIL handshake_timeout actual=%0d cycles required=<3000", n);
    end
    last_hs = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic send_fq(input int maxgap);
    foreach (fq[i]) send_byte(fq[i], $urandom_range(0, maxgap));
    fq.delete();
  endtask

  function automatic logic [7:0] rand_cell();
    int r;
    r = $urandom_range(0, 10);
    return (r == 10) ? 8'h2E : 8'(8'h30 + r);
  endfunction

  task automatic add_cells(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) fq.push_back(skips[$urandom_range(0, 3)]);
      fq.push_back(rand_cell());
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  string s1 = "530070000600195000098000060800060003400803001700020006060000280000419005000080079";
  int e0, p0, n;

  initial begin
    idle_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("reset_valid", board_valid, 1'b0);
    check("reset_err_code", err_code, 2'd0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_board", board, '0);
    check("reset_ready", rx_ready, 1'b1);
    idle_cycles(1);

    // known board, solver ready throughout
    fq.push_back(8'h53);
    for (int i = 0; i < 81; i++) begin
      if (i > 0 && i % 9 == 0) begin fq.push_back(8'h0D); fq.push_back(8'h0A); end
      fq.push_back(s1[i]);
    end
    e0 = valid_rises;
    send_fq(0);
    @(negedge clk);
    check("t1_valid_latency", board_valid, 1'b1);
    check("t1_cell0", board[3:0], 4'd5);
    check("t1_cell2", board[11:8], 4'd0);
    check("t1_cell4", board[19:16], 4'd7);
    @(negedge clk);
    check("t1_valid_one_cycle", board_valid, 1'b0);
    check("t1_valid_rises", valid_rises - e0, 1);
    idle_cycles(1);

    // held board back-pressures an offered byte
    board_ready = 1'b0;
    fq.push_back(8'h53);
    add_cells(81);
    send_fq(2);
    rx_data = 8'h41;
    rx_valid = 1'b1;
    idle_cycles(100);
    @(negedge clk);
    check("t2_valid_held", board_valid, 1'b1);
    check("t2_ready_low", rx_ready, 1'b0);
    idle_cycles(1);
    board_ready = 1'b1;
    send_byte(8'h41, 0);
    check("t2_code_unchanged", err_code, 2'd0);
    idle_cycles(2);

    // bad character aborts, next frame decodes
    fq.push_back(8'h53);
    add_cells(10);
    send_fq(1);
    send_byte(8'h78, 0);
    @(negedge clk);
    check("t3_err_pulse", frame_err, 1'b1);
    check("t3_err_code", err_code, 2'd1);
    @(negedge clk);
    check("t3_err_single", frame_err, 1'b0);
    idle_cycles(1);
    fq.push_back(8'h53);
    for (int i = 0; i < 81; i++) fq.push_back(s1[i]);
    send_fq(1);
    @(negedge clk);
    check("t3_cell4", board[19:16], 4'd7);
    idle_cycles(2);

    // restart mid-frame
    p0 = err_pulses;
    fq.push_back(8'h53);
    add_cells(40);
    send_fq(1);
    send_byte(8'h53, 0);
    @(negedge clk);
    check("t4_restart_code", err_code, 2'd3);
    idle_cycles(1);
    add_cells(81);
    send_fq(1);
    idle_cycles(3);
    check("t4_err_pulses", err_pulses - p0, 1);

    // timeout exactly TO cycles after the last byte
    fq.push_back(8'h53);
    add_cells(5);
    send_fq(0);
    e0 = last_hs;
    n = 0;
    while (!frame_err && n < 40) begin @(negedge clk); n++; end
    check("t5_timeout_latency", cyc - e0, TO);
    check("t5_timeout_code", err_code, 2'd2);
    idle_cycles(1);
    // byte landing on the expiry cycle keeps the frame alive
    p0 = err_pulses;
    e0 = valid_rises;
    for (int i = 0; i < 6; i++) fq.push_back(i == 0 ? 8'h53 : 8'h34);
    send_fq(0);
    send_byte(8'h39, TO - 1);
    for (int i = 0; i < 75; i++) fq.push_back(8'h31);
    send_fq(0);
    idle_cycles(3);
    check("t5_no_err", err_pulses - p0, 0);
    check("t5_frame_done", valid_rises - e0, 1);

    // reset mid-frame discards everything
    fq.push_back(8'h53);
    add_cells(50);
    send_fq(1);
    reset = 1'b1;
    idle_cycles(2);
    reset = 1'b0;
    @(negedge clk);
    check("t6_board_zero", board, '0);
    check("t6_code_zero", err_code, 2'd0);
    check("t6_valid_zero", board_valid, 1'b0);
    idle_cycles(1);
    p0 = err_pulses;
    e0 = valid_rises;
    fq.push_back(8'h53);
    add_cells(81);
    send_fq(2);
    idle_cycles(3);
    check("t6_no_err", err_pulses - p0, 0);
    check("t6_frame_done", valid_rises - e0, 1);

    // randomized frames: clean, bad char, restart, timeout
    for (int f = 0; f < 12; f++) begin
      int kind;
      kind = $urandom_range(0, 3);
      board_ready = $urandom_range(0, 1);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) fq.push_back(junk[$urandom_range(0, 3)]);
      fq.push_back(8'h53);
      case (kind)
        1: begin add_cells($urandom_range(0, 80)); fq.push_back(bads[$urandom_range(0, 3)]); end
        2: begin add_cells($urandom_range(0, 80)); fq.push_back(8'h53); add_cells(81); end
        3: begin add_cells($urandom_range(0, 80)); end
        default: add_cells(81);
      endcase
      send_fq(3);
      if (kind == 3) idle_cycles(TO + 4);
      idle_cycles($urandom_range(0, 8));
      board_ready = 1'b1;
      idle_cycles(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
